// File: rtl/cache_req_pkg.sv
// cache_req_pkg: shared definitions for the cache requester.
//   - Default parameter values (address/data width, retry and back-off limits)
//   - Requester FSM state enumeration
//   - Statistics counter width and saturating increment helper
package cache_req_pkg;

  localparam int unsigned DEF_ADDR_W      = 5;
  localparam int unsigned DEF_DATA_W      = 32;
  localparam int unsigned DEF_MAX_RETRY   = 3;
  localparam int unsigned DEF_BACKOFF_CYC = 2;

  localparam int unsigned STAT_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    SAMPLE,
    BACKOFF,
    RESP
  } state_e;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/cache_requester_if.sv
// cache_requester_if: bundles the core-side request/response handshake and
// the processor-side cache port.
//   master modport : the requester (drives req_ready, rsp_*, cache strobes)
//   slave modport  : the core + cache side (drives requests, rsp_ready,
//                    read_data, match)
interface cache_requester_if
  import cache_req_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) ();

  // Core request channel
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  // Core response channel
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_hit;
  logic              rsp_error;

  // Cache port
  logic [ADDR_W-1:0] fulladdress;
  logic [DATA_W-1:0] write_data;
  logic              write_signal;
  logic              read_signal;
  logic [DATA_W-1:0] read_data;
  logic              match;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready,
    output rsp_valid, rsp_data, rsp_hit, rsp_error,
    input  rsp_ready,
    output fulladdress, write_data, write_signal, read_signal,
    input  read_data, match
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_data, rsp_hit, rsp_error,
    output rsp_ready,
    input  fulladdress, write_data, write_signal, read_signal,
    output read_data, match
  );

endinterface

// File: rtl/cache_req_backoff.sv
// cache_req_backoff: loadable down-counter used to time the idle gap between
// a read miss and its re-issue.
//   clk      : clock, rising edge
//   reset    : asynchronous active-low reset
//   load     : load load_val this cycle (takes priority over counting)
//   load_val : value loaded into the counter
//   done     : counter is at zero
module cache_req_backoff #(
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/cache_requester.sv
// cache_requester: initiator for the processor-side cache port.
// Accepts load/store requests from the core, strobes the cache for one cycle,
// samples match/read_data the following cycle, retries read misses after a
// fixed back-off and returns exactly one response per request.
//   clk, reset : clock and asynchronous active-low reset
//   bus        : cache_requester_if.master (core req/rsp + cache port)
//   stat_hits, stat_misses : saturating hit/miss counters, present only when
//                            CACHE_REQ_STATS_EN is defined
module cache_requester
  import cache_req_pkg::*;
#(
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned MAX_RETRY   = DEF_MAX_RETRY,
  parameter int unsigned BACKOFF_CYC = DEF_BACKOFF_CYC
) (
  input  logic              clk,
  input  logic              reset,
  cache_requester_if.master bus
`ifdef CACHE_REQ_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_hits,
  output logic [STAT_W-1:0] stat_misses
`endif
);

  localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 1);
  localparam int unsigned BO_W    = $clog2(BACKOFF_CYC + 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                write_q, write_d;
  logic [RETRY_W-1:0]  retry_q, retry_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_hit_q, rsp_hit_d;
  logic                rsp_error_q, rsp_error_d;

  logic                bo_load;
  logic                bo_done;

  // Loaded with BACKOFF_CYC-1 so that done rises in the last of the
  // BACKOFF_CYC idle cycles, letting the FSM move to ISSUE on that edge.
  cache_req_backoff #(
    .CNT_W (BO_W)
  ) u_backoff (
    .clk      (clk),
    .reset    (reset),
    .load     (bo_load),
    .load_val (BO_W'(BACKOFF_CYC - 1)),
    .done     (bo_done)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    write_d     = write_q;
    retry_d     = retry_q;
    rsp_data_d  = rsp_data_q;
    rsp_hit_d   = rsp_hit_q;
    rsp_error_d = rsp_error_q;
    bo_load     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          write_d = bus.req_write;
          retry_d = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = SAMPLE;
      end
      SAMPLE: begin
        if (write_q) begin
          rsp_data_d  = '0;
          rsp_hit_d   = bus.match;
          rsp_error_d = 1'b0;
          state_d     = RESP;
        end else if (bus.match) begin
          rsp_data_d  = bus.read_data;
          rsp_hit_d   = 1'b1;
          rsp_error_d = 1'b0;
          state_d     = RESP;
        end else if (retry_q < RETRY_W'(MAX_RETRY)) begin
          retry_d = retry_q + RETRY_W'(1);
          bo_load = 1'b1;
          state_d = BACKOFF;
        end else begin
          rsp_data_d  = '0;
          rsp_hit_d   = 1'b0;
          rsp_error_d = 1'b1;
          state_d     = RESP;
        end
      end
      BACKOFF: begin
        if (bo_done) begin
          state_d = ISSUE;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      retry_q     <= '0;
      rsp_data_q  <= '0;
      rsp_hit_q   <= 1'b0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      write_q     <= write_d;
      retry_q     <= retry_d;
      rsp_data_q  <= rsp_data_d;
      rsp_hit_q   <= rsp_hit_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  // Strobes decode the asynchronously reset state, so they drop the moment
  // reset asserts; req_ready is additionally gated so it is 0 during reset.
  assign bus.req_ready    = (state_q == IDLE) && reset;
  assign bus.write_signal = (state_q == ISSUE) && write_q;
  assign bus.read_signal  = (state_q == ISSUE) && !write_q;
  assign bus.fulladdress  = addr_q;
  assign bus.write_data   = wdata_q;
  assign bus.rsp_valid    = (state_q == RESP);
  assign bus.rsp_data     = rsp_data_q;
  assign bus.rsp_hit      = rsp_hit_q;
  assign bus.rsp_error    = rsp_error_q;

`ifdef CACHE_REQ_STATS_EN
  logic [STAT_W-1:0] hits_q, hits_d;
  logic [STAT_W-1:0] misses_q, misses_d;

  always_comb begin
    hits_d   = hits_q;
    misses_d = misses_q;
    if (state_q == SAMPLE) begin
      if (bus.match) begin
        hits_d = sat_inc(hits_q);
      end else begin
        misses_d = sat_inc(misses_q);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hits_q   <= '0;
      misses_q <= '0;
    end else begin
      hits_q   <= hits_d;
      misses_q <= misses_d;
    end
  end

  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;
`endif

endmodule

// File: tb/tb_cache_requester.sv
module tb_cache_requester;
  import cache_req_pkg::*;

  localparam int unsigned ADDR_W      = 5;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned MAX_RETRY   = 3;
  localparam int unsigned BACKOFF_CYC = 2;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  cache_requester_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  cache_requester #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .MAX_RETRY   (MAX_RETRY),
    .BACKOFF_CYC (BACKOFF_CYC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Cache model: responds on the negedge of the strobe cycle, so match and
  // read_data are stable throughout the following (SAMPLE) cycle.
  logic [DATA_W-1:0] mem [32];
  logic              written [32] = '{default: 1'b0};
  int unsigned cyc = 0, rd_cnt = 0, wr_cnt = 0, rd_last = 0, rd_prev = 0;
  logic        force_miss  = 1'b0;
  logic        store_match = 1'b1;
  int unsigned miss_base = 0, miss_n = 0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus.read_signal) begin
      rd_cnt  <= rd_cnt + 1;
      rd_prev <= rd_last;
      rd_last <= cyc;
      bus.match <= !(force_miss || ((rd_cnt - miss_base) < miss_n));
      bus.read_data <= written[bus.fulladdress] ? mem[bus.fulladdress]
                                                : (32'hA000_0000 | DATA_W'(bus.fulladdress));
    end
    if (bus.write_signal) begin
      wr_cnt <= wr_cnt + 1;
      mem[bus.fulladdress]     <= bus.write_data;
      written[bus.fulladdress] <= 1'b1;
      bus.match     <= store_match;
      bus.read_data <= '0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request and return once the handshake edge has passed.
  task automatic send(input logic w, input logic [4:0] a, input logic [31:0] d);
    int n = 0;
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    while (!bus.req_ready && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (!bus.req_ready) begin
      failures++;
      $display("FAIL send_handshake: req_ready=%0b required=1", bus.req_ready);
    end
    tick();
    bus.req_valid = 1'b0;
  endtask

  // Called right after the handshake edge; lat counts edges from it.
  task automatic wait_rsp(output int lat, output logic [31:0] data,
                          output logic hit, output logic err);
    lat = 1;
    while (!bus.rsp_valid && lat < 100) begin
      tick();
      lat++;
    end
    data = bus.rsp_data;
    hit  = bus.rsp_hit;
    err  = bus.rsp_error;
  endtask

  task automatic txn(input logic w, input logic [4:0] a, input logic [31:0] d,
                     output int lat, output logic [31:0] data,
                     output logic hit, output logic err);
    bus.rsp_ready = 1'b1;
    send(w, a, d);
    wait_rsp(lat, data, hit, err);
    tick();
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_hit, bus.rsp_error,
         bus.write_signal, bus.read_signal} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b required 000000",
               {bus.req_ready, bus.rsp_valid, bus.rsp_hit, bus.rsp_error,
                bus.write_signal, bus.read_signal});
    end
    checks++;
    if ({bus.fulladdress, bus.write_data, bus.rsp_data} !== '0) begin
      failures++;
      $display("FAIL reset_data: addr=%h wdata=%h rdata=%h required 0",
               bus.fulladdress, bus.write_data, bus.rsp_data);
    end
    tick();
    tick();
    reset = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready: got %b required 1", bus.req_ready);
    end
  endtask

  task automatic test_stores();
    int lat; logic [31:0] data; logic hit, err;
    int unsigned wr0, rd0;
    wr0 = wr_cnt; rd0 = rd_cnt;
    txn(1'b1, 5'd1, 32'd5, lat, data, hit, err);
    checks++;
    if ({lat, data, hit, err} !== {32'd3, 32'd0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL store1_rsp: lat=%0d data=%h hit=%b err=%b required 3 0 1 0", lat, data, hit, err);
    end
    checks++;
    if ((wr_cnt - wr0) !== 1 || (rd_cnt - rd0) !== 0) begin
      failures++;
      $display("FAIL store1_pulses: wr=%0d rd=%0d required 1 0", wr_cnt - wr0, rd_cnt - rd0);
    end
    wr0 = wr_cnt;
    txn(1'b1, 5'd2, 32'd6, lat, data, hit, err);
    checks++;
    if ({lat, data, err} !== {32'd3, 32'd0, 1'b0}) begin
      failures++;
      $display("FAIL store2_rsp: lat=%0d data=%h err=%b required 3 0 0", lat, data, err);
    end
    checks++;
    if ((wr_cnt - wr0) !== 1) begin
      failures++;
      $display("FAIL store2_pulses: wr=%0d required 1", wr_cnt - wr0);
    end
  endtask

  task automatic test_store_miss();
    int lat; logic [31:0] data; logic hit, err;
    int unsigned wr0;
    wr0 = wr_cnt;
    store_match = 1'b0;
    txn(1'b1, 5'd4, 32'd9, lat, data, hit, err);
    store_match = 1'b1;
    checks++;
    if ({lat, hit, err} !== {32'd3, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL store_miss_rsp: lat=%0d hit=%b err=%b required 3 0 0", lat, hit, err);
    end
    checks++;
    if ((wr_cnt - wr0) !== 1) begin
      failures++;
      $display("FAIL store_miss_no_retry: wr=%0d required 1", wr_cnt - wr0);
    end
  endtask

  task automatic test_load_hit();
    int lat; logic [31:0] data; logic hit, err;
    int unsigned wr0, rd0;
    wr0 = wr_cnt; rd0 = rd_cnt;
    txn(1'b0, 5'd1, 32'h0, lat, data, hit, err);
    checks++;
    if ({lat, data, hit, err} !== {32'd3, 32'd5, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL load_hit_rsp: lat=%0d data=%h hit=%b err=%b required 3 5 1 0", lat, data, hit, err);
    end
    checks++;
    if ((rd_cnt - rd0) !== 1 || (wr_cnt - wr0) !== 0) begin
      failures++;
      $display("FAIL load_hit_pulses: rd=%0d wr=%0d required 1 0", rd_cnt - rd0, wr_cnt - wr0);
    end
  endtask

  task automatic test_load_retry();
    int lat; logic [31:0] data; logic hit, err;
    int unsigned rd0;
    rd0 = rd_cnt;
    miss_base = rd_cnt;
    miss_n = 1;
    txn(1'b0, 5'd3, 32'h0, lat, data, hit, err);
    miss_n = 0;
    checks++;
    if ({lat, data, hit, err} !== {32'd7, 32'hA000_0003, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL load_retry_rsp: lat=%0d data=%h hit=%b err=%b required 7 a0000003 1 0", lat, data, hit, err);
    end
    checks++;
    if ((rd_cnt - rd0) !== 2) begin
      failures++;
      $display("FAIL load_retry_pulses: rd=%0d required 2", rd_cnt - rd0);
    end
    checks++;
    if ((rd_last - rd_prev) !== 4) begin
      failures++;
      $display("FAIL load_retry_spacing: got %0d required 4", rd_last - rd_prev);
    end
  endtask

  task automatic test_error();
    int lat; logic [31:0] data; logic hit, err;
    int unsigned rd0;
    rd0 = rd_cnt;
    force_miss = 1'b1;
    txn(1'b0, 5'd7, 32'h0, lat, data, hit, err);
    force_miss = 1'b0;
    checks++;
    if ({lat, hit, err} !== {32'd15, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL error_rsp: lat=%0d hit=%b err=%b required 15 0 1", lat, hit, err);
    end
    checks++;
    if ((rd_cnt - rd0) !== 4) begin
      failures++;
      $display("FAIL error_pulses: rd=%0d required 4", rd_cnt - rd0);
    end
    checks++;
    if ((rd_last - rd_prev) !== 4) begin
      failures++;
      $display("FAIL error_spacing: got %0d required 4", rd_last - rd_prev);
    end
  endtask

  task automatic test_back_to_back_stall();
    int lat; logic [31:0] data; logic hit, err;
    int unsigned wr0;
    logic bad_fields = 1'b0, bad_ready = 1'b0;
    bus.rsp_ready = 1'b0;
    send(1'b0, 5'd2, 32'h0);
    wait_rsp(lat, data, hit, err);
    checks++;
    if ({lat, data, hit, err} !== {32'd3, 32'd6, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL stall_first_rsp: lat=%0d data=%h hit=%b err=%b required 3 6 1 0", lat, data, hit, err);
    end
    wr0 = wr_cnt;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 5'd5;
    bus.req_wdata = 32'h0000_1234;
    for (int i = 0; i < 5; i++) begin
      tick();
      if ({bus.rsp_valid, bus.rsp_data, bus.rsp_hit, bus.rsp_error} !== {1'b1, 32'd6, 1'b1, 1'b0})
        bad_fields = 1'b1;
      if (bus.req_ready !== 1'b0)
        bad_ready = 1'b1;
    end
    checks++;
    if (bad_fields) begin
      failures++;
      $display("FAIL stall_fields_stable: valid=%b data=%h required 1 6", bus.rsp_valid, bus.rsp_data);
    end
    checks++;
    if (bad_ready || (wr_cnt - wr0) !== 0) begin
      failures++;
      $display("FAIL stall_no_accept: ready_seen=%b wr=%0d required 0 0", bad_ready, wr_cnt - wr0);
    end
    bus.rsp_ready = 1'b1;
    tick();
    checks++;
    if ({bus.rsp_valid, bus.req_ready} !== 2'b01) begin
      failures++;
      $display("FAIL stall_release: valid=%b ready=%b required 0 1", bus.rsp_valid, bus.req_ready);
    end
    tick();
    bus.req_valid = 1'b0;
    wait_rsp(lat, data, hit, err);
    tick();
    checks++;
    if ({lat, data, err} !== {32'd3, 32'd0, 1'b0} || (wr_cnt - wr0) !== 1) begin
      failures++;
      $display("FAIL stall_next_req: lat=%0d data=%h err=%b wr=%0d required 3 0 0 1", lat, data, err, wr_cnt - wr0);
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] data; logic hit, err;
    int unsigned rd0;
    logic bad = 1'b0;
    rd0 = rd_cnt;
    force_miss = 1'b1;
    bus.rsp_ready = 1'b1;
    send(1'b0, 5'd6, 32'hDEAD_BEEF);
    tick();
    tick();
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({bus.req_ready, bus.rsp_valid, bus.write_signal, bus.read_signal,
         bus.fulladdress, bus.write_data, bus.rsp_data} !== '0) begin
      failures++;
      $display("FAIL reset_mid_outputs: ready=%b valid=%b addr=%h wdata=%h required all 0",
               bus.req_ready, bus.rsp_valid, bus.fulladdress, bus.write_data);
    end
    tick();
    reset = 1'b1;
    force_miss = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.rsp_valid !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad || (rd_cnt - rd0) !== 1) begin
      failures++;
      $display("FAIL reset_mid_discard: rsp_seen=%b rd=%0d required 0 1", bad, rd_cnt - rd0);
    end
    txn(1'b0, 5'd5, 32'h0, lat, data, hit, err);
    checks++;
    if ({lat, data, hit, err} !== {32'd3, 32'h0000_1234, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL reset_mid_next: lat=%0d data=%h hit=%b err=%b required 3 1234 1 0", lat, data, hit, err);
    end
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b1;
    test_reset();
    test_stores();
    test_store_miss();
    test_load_hit();
    test_load_retry();
    test_error();
    test_back_to_back_stall();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
